// File: rtl/writeback_stage.sv
// Final pipeline stage: formats load data and drives the register-file write port one cycle after retirement.
// Stalls upstream (outReady=0) only while a load waits for its data-cache response.
module writeback_stage #(
   parameter int BUS_DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      inValid,
   output logic                      outReady,
   input  logic                      inRegWrite,
   input  logic                      inMemOrReg,
   input  logic [4:0]                inDestRegister,
   input  logic [BUS_DATA_WIDTH-1:0] inAluResult,
   input  logic [2:0]                inLoadType,
   input  logic [2:0]                inAddrLow,
   input  logic                      inMemDataValid,
   input  logic [BUS_DATA_WIDTH-1:0] inMemData,
   output logic                      outRegWrite,
   output logic [4:0]                outDestRegister,
   output logic [BUS_DATA_WIDTH-1:0] outRegData,
   output logic [31:0]               outRetireCount
);

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [4:0]                pend_dest_q, pend_dest_d;
   logic                      pend_wr_q, pend_wr_d;
   logic [2:0]                pend_type_q, pend_type_d;
   logic [2:0]                pend_off_q, pend_off_d;
   logic                      reg_write_q, reg_write_d;
   logic [4:0]                dest_q, dest_d;
   logic [BUS_DATA_WIDTH-1:0] data_q, data_d;
   logic [31:0]               retire_count_q, retire_count_d;

   logic                      retire;
   logic                      ret_wr;
   logic [4:0]                ret_dest;
   logic [BUS_DATA_WIDTH-1:0] ret_data;

   // Narrow loads select their lane by shifting the doubleword down; low offset bits below the lane size are ignored.
   function automatic logic [BUS_DATA_WIDTH-1:0] format_load(
      input logic [2:0]                load_type,
      input logic [2:0]                off,
      input logic [BUS_DATA_WIDTH-1:0] data
   );
      logic [BUS_DATA_WIDTH-1:0] b_sh;
      logic [BUS_DATA_WIDTH-1:0] h_sh;
      logic [BUS_DATA_WIDTH-1:0] w_sh;
      b_sh = data >> {off, 3'b000};
      h_sh = data >> {off[2:1], 4'b0000};
      w_sh = data >> {off[2], 5'b00000};
      case (load_type)
         3'b001:  return {{56{b_sh[7]}},  b_sh[7:0]};
         3'b010:  return {{48{h_sh[15]}}, h_sh[15:0]};
         3'b011:  return {{32{w_sh[31]}}, w_sh[31:0]};
         3'b100:  return {56'd0, b_sh[7:0]};
         3'b101:  return {48'd0, h_sh[15:0]};
         3'b110:  return {32'd0, w_sh[31:0]};
         default: return data;
      endcase
   endfunction

   always_comb begin
      state_d        = state_q;
      pend_dest_d    = pend_dest_q;
      pend_wr_d      = pend_wr_q;
      pend_type_d    = pend_type_q;
      pend_off_d     = pend_off_q;
      reg_write_d    = 1'b0;
      dest_d         = dest_q;
      data_d         = data_q;
      retire_count_d = retire_count_q;
      retire         = 1'b0;
      ret_wr         = 1'b0;
      ret_dest       = 5'd0;
      ret_data       = '0;

      case (state_q)
         IDLE: begin
            if (inValid) begin
               if (!inMemOrReg) begin
                  retire   = 1'b1;
                  ret_wr   = inRegWrite;
                  ret_dest = inDestRegister;
                  ret_data = inAluResult;
               end else if (inMemDataValid) begin
                  retire   = 1'b1;
                  ret_wr   = inRegWrite;
                  ret_dest = inDestRegister;
                  ret_data = format_load(inLoadType, inAddrLow, inMemData);
               end else begin
                  pend_dest_d = inDestRegister;
                  pend_wr_d   = inRegWrite;
                  pend_type_d = inLoadType;
                  pend_off_d  = inAddrLow;
                  state_d     = WAIT_LOAD;
               end
            end
         end
         WAIT_LOAD: begin
            if (inMemDataValid) begin
               retire   = 1'b1;
               ret_wr   = pend_wr_q;
               ret_dest = pend_dest_q;
               ret_data = format_load(pend_type_q, pend_off_q, inMemData);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Suppressed x0 writes and non-writing instructions still count as retired.
      if (retire) begin
         reg_write_d    = ret_wr && (ret_dest != 5'd0);
         dest_d         = ret_dest;
         data_d         = ret_data;
         retire_count_d = retire_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         pend_dest_q    <= 5'd0;
         pend_wr_q      <= 1'b0;
         pend_type_q    <= 3'd0;
         pend_off_q     <= 3'd0;
         reg_write_q    <= 1'b0;
         dest_q         <= 5'd0;
         data_q         <= '0;
         retire_count_q <= 32'd0;
      end else begin
         state_q        <= state_d;
         pend_dest_q    <= pend_dest_d;
         pend_wr_q      <= pend_wr_d;
         pend_type_q    <= pend_type_d;
         pend_off_q     <= pend_off_d;
         reg_write_q    <= reg_write_d;
         dest_q         <= dest_d;
         data_q         <= data_d;
         retire_count_q <= retire_count_d;
      end
   end

   assign outReady        = (state_q == IDLE);
   assign outRegWrite     = reg_write_q;
   assign outDestRegister = dest_q;
   assign outRegData      = data_q;
   assign outRetireCount  = retire_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_writeback_stage;

   logic        clk;
   logic        reset;
   logic        inValid;
   logic        outReady;
   logic        inRegWrite;
   logic        inMemOrReg;
   logic [4:0]  inDestRegister;
   logic [63:0] inAluResult;
   logic [2:0]  inLoadType;
   logic [2:0]  inAddrLow;
   logic        inMemDataValid;
   logic [63:0] inMemData;
   logic        outRegWrite;
   logic [4:0]  outDestRegister;
   logic [63:0] outRegData;
   logic [31:0] outRetireCount;

   int errors = 0;
   int checks = 0;

   writeback_stage #(.BUS_DATA_WIDTH(64)) dut (
      .clk             (clk),
      .reset           (reset),
      .inValid         (inValid),
      .outReady        (outReady),
      .inRegWrite      (inRegWrite),
      .inMemOrReg      (inMemOrReg),
      .inDestRegister  (inDestRegister),
      .inAluResult     (inAluResult),
      .inLoadType      (inLoadType),
      .inAddrLow       (inAddrLow),
      .inMemDataValid  (inMemDataValid),
      .inMemData       (inMemData),
      .outRegWrite     (outRegWrite),
      .outDestRegister (outDestRegister),
      .outRegData      (outRegData),
      .outRetireCount  (outRetireCount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference load formatter written from the byte/half/word lane rules with plain arithmetic.
   function automatic logic [63:0] ref_fmt(input int lt, input int off, input logic [63:0] d);
      logic [63:0] b, h, w;
      b = (d >> (8 * off)) & 64'hFF;
      h = (d >> (16 * (off / 2))) & 64'hFFFF;
      w = (d >> (32 * (off / 4))) & 64'hFFFF_FFFF;
      case (lt)
         1: return (b >= 64'h80)        ? (b | 64'hFFFF_FFFF_FFFF_FF00) : b;
         2: return (h >= 64'h8000)      ? (h | 64'hFFFF_FFFF_FFFF_0000) : h;
         3: return (w >= 64'h8000_0000) ? (w | 64'hFFFF_FFFF_0000_0000) : w;
         4: return b;
         5: return h;
         6: return w;
         default: return d;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      inValid        = 1'b0;
      inRegWrite     = 1'b0;
      inMemOrReg     = 1'b0;
      inDestRegister = 5'd0;
      inAluResult    = 64'd0;
      inLoadType     = 3'd0;
      inAddrLow      = 3'd0;
      inMemDataValid = 1'b0;
      inMemData      = 64'd0;
   endtask

   task automatic drive_alu(input logic [4:0] dest, input logic [63:0] val);
      inValid        = 1'b1;
      inRegWrite     = 1'b1;
      inMemOrReg     = 1'b0;
      inDestRegister = dest;
      inAluResult    = val;
      inMemDataValid = 1'b0;
   endtask

   // Called between edges: asserts reset, holds it across one edge, releases just after that edge.
   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (outRegWrite !== 1'b0 || outRetireCount !== 32'd0 || outReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_initial: we=%b count=%h ready=%b, need we=0 count=0 ready=1",
                  outRegWrite, outRetireCount, outReady);
      end
      step();
      reset = 1'b0;
      drive_alu(5'd3, 64'h55);
      step();
      idle_inputs();
      checks++;
      if (outRegWrite !== 1'b1 || outRegData !== 64'h55 || outRetireCount !== 32'd1) begin
         errors++;
         $display("FAIL reset_prefill: we=%b data=%h count=%h, need we=1 data=55 count=1",
                  outRegWrite, outRegData, outRetireCount);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (outRegWrite !== 1'b0 || outDestRegister !== 5'd0 || outRegData !== 64'd0 ||
          outRetireCount !== 32'd0 || outReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_async: we=%b dest=%0d data=%h count=%h ready=%b, need all 0 and ready=1",
                  outRegWrite, outDestRegister, outRegData, outRetireCount, outReady);
      end
      step();
      reset = 1'b0;
   endtask

   task automatic test_alu_stream();
      logic [4:0]  dests [3];
      logic [63:0] vals  [3];
      logic        wes   [3];
      dests = '{5'd5, 5'd0, 5'd6};
      vals  = '{64'h1234, 64'hFFFF, 64'hDEAD};
      wes   = '{1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_alu(dests[i], vals[i]);
         checks++;
         if (outReady !== 1'b1) begin
            errors++;
            $display("FAIL alu_ready[%0d]: ready=%b, need 1", i, outReady);
         end
         step();
         checks++;
         if (outRegWrite !== wes[i] || (wes[i] && (outDestRegister !== dests[i] || outRegData !== vals[i]))) begin
            errors++;
            $display("FAIL alu_write[%0d]: we=%b dest=%0d data=%h, need we=%b dest=%0d data=%h",
                     i, outRegWrite, outDestRegister, outRegData, wes[i], dests[i], vals[i]);
         end
      end
      idle_inputs();
      step();
      checks++;
      if (outRegWrite !== 1'b0 || outRetireCount !== 32'd3) begin
         errors++;
         $display("FAIL alu_count: we=%b count=%0d, need we=0 count=3", outRegWrite, outRetireCount);
      end
   endtask

   task automatic test_load_format();
      logic [2:0]  types [6];
      logic [2:0]  offs  [6];
      logic [63:0] exps  [6];
      types = '{3'b001, 3'b100, 3'b010, 3'b011, 3'b110, 3'b000};
      offs  = '{3'd7, 3'd7, 3'd2, 3'd4, 3'd4, 3'd5};
      exps  = '{64'hFFFF_FFFF_FFFF_FF88, 64'h88, 64'h4433, 64'hFFFF_FFFF_8877_6655,
                64'h8877_6655, 64'h8877_6655_4433_2211};
      for (int i = 0; i < 6; i++) begin
         inValid        = 1'b1;
         inRegWrite     = 1'b1;
         inMemOrReg     = 1'b1;
         inDestRegister = 5'(10 + i);
         inLoadType     = types[i];
         inAddrLow      = offs[i];
         inMemDataValid = 1'b1;
         inMemData      = 64'h8877_6655_4433_2211;
         step();
         checks++;
         if (outRegWrite !== 1'b1 || outDestRegister !== 5'(10 + i) || outRegData !== exps[i]) begin
            errors++;
            $display("FAIL load_fmt[%0d]: we=%b dest=%0d data=%h, need we=1 dest=%0d data=%h",
                     i, outRegWrite, outDestRegister, outRegData, 10 + i, exps[i]);
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_delayed_load();
      int x7_writes;
      x7_writes = 0;
      do_reset();
      inValid        = 1'b1;
      inRegWrite     = 1'b1;
      inMemOrReg     = 1'b1;
      inDestRegister = 5'd7;
      inLoadType     = 3'b011;
      inAddrLow      = 3'd4;
      inMemDataValid = 1'b0;
      step();
      drive_alu(5'd9, 64'h99);
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (outReady !== 1'b0) begin
            errors++;
            $display("FAIL delayed_ready_low[%0d]: ready=%b, need 0", c, outReady);
         end
         if (outRegWrite === 1'b1 && outDestRegister === 5'd7) x7_writes++;
         if (c == 4) begin
            inMemDataValid = 1'b1;
            inMemData      = 64'h8877_6655_4433_2211;
         end
         step();
      end
      inMemDataValid = 1'b0;
      checks++;
      if (outRegWrite !== 1'b1 || outDestRegister !== 5'd7 || outRegData !== 64'hFFFF_FFFF_8877_6655 ||
          outReady !== 1'b1) begin
         errors++;
         $display("FAIL delayed_pulse: we=%b dest=%0d data=%h ready=%b, need we=1 dest=7 data=ffffffff88776655 ready=1",
                  outRegWrite, outDestRegister, outRegData, outReady);
      end
      if (outRegWrite === 1'b1 && outDestRegister === 5'd7) x7_writes++;
      step();
      idle_inputs();
      checks++;
      if (outRegWrite !== 1'b1 || outDestRegister !== 5'd9 || outRegData !== 64'h99) begin
         errors++;
         $display("FAIL delayed_alu: we=%b dest=%0d data=%h, need we=1 dest=9 data=99",
                  outRegWrite, outDestRegister, outRegData);
      end
      step();
      checks++;
      if (x7_writes !== 1 || outRegWrite !== 1'b0 || outRetireCount !== 32'd2) begin
         errors++;
         $display("FAIL delayed_totals: x7_writes=%0d we=%b count=%0d, need 1 0 2",
                  x7_writes, outRegWrite, outRetireCount);
      end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      inValid        = 1'b1;
      inRegWrite     = 1'b1;
      inMemOrReg     = 1'b1;
      inDestRegister = 5'd8;
      inLoadType     = 3'b000;
      step();
      idle_inputs();
      checks++;
      if (outReady !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_entered: ready=%b, need 0", outReady);
      end
      #2 reset = 1'b1;
      step();
      reset          = 1'b0;
      inMemDataValid = 1'b1;
      inMemData      = 64'hABCD;
      step();
      inMemDataValid = 1'b0;
      checks++;
      if (outRegWrite !== 1'b0 || outRetireCount !== 32'd0 || outReady !== 1'b1) begin
         errors++;
         $display("FAIL rst_wait_dropped: we=%b count=%0d ready=%b, need we=0 count=0 ready=1",
                  outRegWrite, outRetireCount, outReady);
      end
      step();
      checks++;
      if (outRegWrite !== 1'b0 || outRetireCount !== 32'd0) begin
         errors++;
         $display("FAIL rst_wait_after: we=%b count=%0d, need we=0 count=0", outRegWrite, outRetireCount);
      end
   endtask

   task automatic test_counter_wrap();
      logic [31:0] exp_counts [3];
      exp_counts = '{32'hFFFF_FFFF, 32'h0, 32'h1};
      do_reset();
      force dut.retire_count_q = 32'hFFFF_FFFE;
      #1 inAluResult = 64'h1;
      step();
      release dut.retire_count_q;
      #1;
      checks++;
      if (outRetireCount !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL wrap_preset: count=%h, need fffffffe", outRetireCount);
      end
      for (int i = 0; i < 3; i++) begin
         drive_alu(5'(20 + i), 64'(i));
         step();
         checks++;
         if (outRetireCount !== exp_counts[i]) begin
            errors++;
            $display("FAIL wrap_count[%0d]: count=%h, need %h", i, outRetireCount, exp_counts[i]);
         end
      end
      idle_inputs();
      step();
   endtask

   // Transaction-level model: an instruction either retires in its acceptance cycle or parks as one pending load.
   task automatic test_random();
      bit          busy;
      bit          p_wr;
      int          p_dest, p_type, p_off;
      bit          e_we;
      logic [4:0]  e_dest;
      logic [63:0] e_data;
      logic [31:0] e_count;
      bit          ret;
      bit          r_wr;
      int          r_dest;
      logic [63:0] r_data;
      do_reset();
      busy = 0; p_wr = 0; p_dest = 0; p_type = 0; p_off = 0;
      e_we = 0; e_dest = 0; e_data = 0; e_count = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         inValid        = ($urandom_range(0, 9) < 7);
         inRegWrite     = ($urandom_range(0, 9) < 8);
         inMemOrReg     = $urandom_range(0, 1);
         inDestRegister = 5'($urandom_range(0, 31));
         inAluResult    = {$urandom, $urandom};
         inLoadType     = 3'($urandom_range(0, 7));
         inAddrLow      = 3'($urandom_range(0, 7));
         inMemDataValid = ($urandom_range(0, 9) < 3);
         inMemData      = {$urandom, $urandom};
         checks++;
         if (outReady !== !busy) begin
            errors++;
            $display("FAIL rand_ready[%0d]: ready=%b, need %b", cyc, outReady, !busy);
         end
         ret = 0; r_wr = 0; r_dest = 0; r_data = 0;
         if (busy) begin
            if (inMemDataValid) begin
               ret = 1; r_wr = p_wr; r_dest = p_dest;
               r_data = ref_fmt(p_type, p_off, inMemData);
               busy = 0;
            end
         end else if (inValid) begin
            if (!inMemOrReg) begin
               ret = 1; r_wr = inRegWrite; r_dest = inDestRegister; r_data = inAluResult;
            end else if (inMemDataValid) begin
               ret = 1; r_wr = inRegWrite; r_dest = inDestRegister;
               r_data = ref_fmt(inLoadType, inAddrLow, inMemData);
            end else begin
               busy = 1; p_wr = inRegWrite; p_dest = inDestRegister;
               p_type = inLoadType; p_off = inAddrLow;
            end
         end
         e_we = ret && r_wr && (r_dest != 0);
         if (ret) begin
            e_dest  = 5'(r_dest);
            e_data  = r_data;
            e_count = e_count + 1;
         end
         step();
         checks++;
         if (outRegWrite !== e_we || outDestRegister !== e_dest || outRegData !== e_data ||
             outRetireCount !== e_count) begin
            errors++;
            $display("FAIL rand_out[%0d]: we=%b dest=%0d data=%h count=%0d, need we=%b dest=%0d data=%h count=%0d",
                     cyc, outRegWrite, outDestRegister, outRegData, outRetireCount,
                     e_we, e_dest, e_data, e_count);
         end
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_alu_stream();
      test_load_format();
      test_delayed_load();
      test_reset_in_wait();
      test_counter_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
